fpu_req_driver: RTL

Hardware initiator for the `fpu` start/done protocol. It accepts operation commands (op, A, B) on a valid/ready stream and drives one `fpu` operation at a time, pulsing `start` and holding operands stable until `done`. It then captures `R` and returns it on a valid/ready result stream. It sits between the command source (sequencer or host bridge) and the `fpu` instance, replacing stimulus that would otherwise be hand-driven.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fpu_req_driver_if.sv | 40 ++++
 rtl/fpu_req_watchdog.sv | 30 +++
 rtl/fpu_req_driver.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu start/done protocol and its request driver.
package fpu_pkg;

    localparam int          FP32_W    = 32;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FPU_ADD = 2'b00,
        FPU_SUB = 2'b01,
        FPU_MUL = 2'b10,
        FPU_DIV = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HOLD  = 2'b11
    } drv_state_e;

endpackage

// File: rtl/fpu_req_driver_if.sv
// Bundles the command stream, result stream and fpu-side signals of the request driver.
interface fpu_req_driver_if;
    import fpu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [FP32_W-1:0] cmd_a;
    logic [FP32_W-1:0] cmd_b;

    logic              res_valid;
    logic              res_ready;
    logic [FP32_W-1:0] res_data;
    logic [1:0]        res_op;
    logic              res_err;

    logic              fpu_start;
    logic [1:0]        fpu_op;
    logic [FP32_W-1:0] fpu_a;
    logic [FP32_W-1:0] fpu_b;
    logic [FP32_W-1:0] fpu_r;
    logic              fpu_done;

    logic              busy;

    // Driver side
    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, fpu_r, fpu_done,
        output cmd_ready, res_valid, res_data, res_op, res_err,
               fpu_start, fpu_op, fpu_a, fpu_b, busy
    );

    // Command source, result consumer and fpu side
    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready, fpu_r, fpu_done,
        input  cmd_ready, res_valid, res_data, res_op, res_err,
               fpu_start, fpu_op, fpu_a, fpu_b, busy
    );

endinterface

// File: rtl/fpu_req_watchdog.sv
// Clear/enable/expire counter that abandons a stalled fpu operation; used only when
// FPU_REQ_TIMEOUT_EN is defined. expire is high on the TIMEOUT_CYCLES-th enabled edge.
module fpu_req_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && (cnt_reg != LAST_CNT)) begin
            // Saturate so a held enable never wraps back into a false non-expiry
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign expire = enable && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/fpu_req_driver.sv
// Initiator for the fpu start/done protocol: one operation in flight, registered start pulse,
// operands held until done, result returned on a valid/ready stream. Optional FPU_REQ_TIMEOUT_EN.
module fpu_req_driver
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    fpu_req_driver_if.master bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("fpu_req_driver: TIMEOUT_CYCLES must be within 2..65535");
    end

    drv_state_e        state_reg, state_next;
    logic              accept;
    logic              done_hit;
    logic              start_reg;
    fpu_op_e           op_reg;
    logic [FP32_W-1:0] a_reg, b_reg;
    logic [FP32_W-1:0] res_data_reg;
    fpu_op_e           res_op_reg;

`ifdef FPU_REQ_TIMEOUT_EN
    logic expire;
    logic timeout_hit;
    logic res_err_reg;

    fpu_req_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != ST_WAIT),
        .enable (state_reg == ST_WAIT),
        .expire (expire)
    );
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        done_hit   = 1'b0;
`ifdef FPU_REQ_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            // done during the start cycle belongs to nothing we issued
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.fpu_done) begin
                    done_hit   = 1'b1;
                    state_next = ST_HOLD;
                end
`ifdef FPU_REQ_TIMEOUT_EN
                else if (expire) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_HOLD;
                end
`endif
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            start_reg    <= 1'b0;
            op_reg       <= FPU_ADD;
            a_reg        <= '0;
            b_reg        <= '0;
            res_data_reg <= '0;
            res_op_reg   <= FPU_ADD;
        end else begin
            state_reg <= state_next;
            start_reg <= accept;
            if (accept) begin
                op_reg <= fpu_op_e'(bus.cmd_op);
                a_reg  <= bus.cmd_a;
                b_reg  <= bus.cmd_b;
            end
            if (done_hit) begin
                res_data_reg <= bus.fpu_r;
                res_op_reg   <= op_reg;
            end
`ifdef FPU_REQ_TIMEOUT_EN
            else if (timeout_hit) begin
                res_data_reg <= FP32_QNAN;
                res_op_reg   <= op_reg;
            end
`endif
        end
    end

`ifdef FPU_REQ_TIMEOUT_EN
    // done outranks timeout on the same edge, so done_hit is checked first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err_reg <= 1'b0;
        end else if (done_hit) begin
            res_err_reg <= 1'b0;
        end else if (timeout_hit) begin
            res_err_reg <= 1'b1;
        end
    end
    assign bus.res_err = res_err_reg;
`else
    assign bus.res_err = 1'b0;
`endif

    // Ready is masked by rst so it reads 0 for the whole reset pulse
    assign bus.cmd_ready = (state_reg == ST_IDLE) && !rst;
    assign bus.res_valid = (state_reg == ST_HOLD);
    assign bus.res_data  = res_data_reg;
    assign bus.res_op    = res_op_reg;
    assign bus.fpu_start = start_reg;
    assign bus.fpu_op    = op_reg;
    assign bus.fpu_a     = a_reg;
    assign bus.fpu_b     = b_reg;
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule
